// File: rtl/mult_seq_ctrl.sv
// Step-counted sequencer for a shift-add/subtract multiplier.
// Final multiplier bit subtracts in signed mode so B acts as a two's-complement weight.
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Run,
  input  logic                         ClearA_LoadB,
  input  logic                         Mode,
  input  logic                         M,
  output logic                         Clr_Ld,
  output logic                         ClearA,
  output logic                         Add,
  output logic                         Sub,
  output logic                         Shift,
  output logic                         Sign_Ext,
  output logic                         Busy,
  output logic                         Done,
  output logic [$clog2(WIDTH+1)-1:0]   Count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EVAL, SHIFT, HALT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          mode_q, mode_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (Run) begin
          mode_d  = Mode;
          count_d = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (M) begin
          state_d = SHIFT;
        end else begin
          count_d = count_q + CW'(1);
          state_d = (count_q == LAST) ? HALT : EVAL;
        end
      end
      SHIFT: begin
        count_d = count_q + CW'(1);
        state_d = (count_q == LAST) ? HALT : EVAL;
      end
      HALT: begin
        // Run must drop before re-arming, so a held button cannot restart.
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    Clr_Ld = 1'b0;
    ClearA = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    if (Reset) begin
      ClearA = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (Run) begin
            ClearA = 1'b1;
          end else begin
            Clr_Ld = ClearA_LoadB;
            ClearA = ClearA_LoadB;
          end
        end
        EVAL: begin
          Busy = 1'b1;
          if (M) begin
            if ((count_q == LAST) && mode_q) Sub = 1'b1;
            else                             Add = 1'b1;
          end else begin
            Shift = 1'b1;
          end
        end
        SHIFT: begin
          Busy  = 1'b1;
          Shift = 1'b1;
        end
        HALT: Done = 1'b1;
        default: ;
      endcase
    end
  end

  assign Sign_Ext = (state_q == IDLE) ? Mode : mode_q;
  assign Count    = count_q;

endmodule
